// File: rtl/ikaopll_slot_timinggen_p.sv
// Parametrised OPLL timing generator: phi1 enable divider, slot sequencer,
// frame counter, slot-match strobe, delayed slot index and operator decode.
module ikaopll_slot_timinggen_p #(
  parameter int                PHI_DIV       = 2,
  parameter int                SUBCYC        = 6,
  parameter int                GROUPS        = 3,
  parameter logic [SUBCYC-1:0] MNC_MASK      = SUBCYC'(6'b100011),
  parameter int                RHY_GRP       = 2,
  parameter logic [SUBCYC-1:0] RHY_NOFB_MASK = SUBCYC'(6'b001100),
  parameter int                DLY           = 2,
  parameter int                FCW           = 8,
  localparam int               SW            = $clog2(SUBCYC*GROUPS)
) (
  input  logic           i_EMUCLK,
  input  logic           i_IC_n,
  input  logic           i_phiM_PCEN_n,
  input  logic           i_PHASE_RST,
  input  logic           i_RHYTHM_EN,
  input  logic [SW-1:0]  i_CMP_SLOT,
  output logic           o_phi1_PCEN_n,
  output logic           o_phi1_NCEN_n,
  output logic           o_DAC_EN,
  output logic [2:0]     o_SUB,
  output logic [1:0]     o_GRP,
  output logic [SW-1:0]  o_SLOT,
  output logic [SW-1:0]  o_SLOT_ZZ,
  output logic           o_FRAME_START,
  output logic [FCW-1:0] o_FRAME_CNT,
  output logic           o_CMP_HIT,
  output logic           o_MnC_SEL,
  output logic           o_INHIBIT_FDBK,
  output logic           o_HH_TT_SEL
);

  localparam int PW = $clog2(PHI_DIV);
  localparam logic [7:0] MNC8  = 8'(MNC_MASK);
  localparam logic [7:0] NOFB8 = 8'(RHY_NOFB_MASK);

  logic [PW-1:0]  phicnt_q, phicnt_d;
  logic [2:0]     sub_q, sub_d;
  logic [1:0]     grp_q, grp_d;
  logic [FCW-1:0] frame_q, frame_d;
  logic           hit_q, hit_d;
  logic           hh_q, hh_d;
  logic [SW-1:0]  dly_q [DLY];
  logic [SW-1:0]  dly_d [DLY];

  logic          en, realign, pcen, ncen;
  logic          sub_last, grp_last;
  logic          rhy_grp, mnc, hh_next;
  logic [SW-1:0] slot;

  always_comb begin
    en       = ~i_phiM_PCEN_n;
    realign  = en & i_PHASE_RST;
    pcen     = en & ~i_PHASE_RST & (phicnt_q == '0);
    ncen     = en & ~i_PHASE_RST & (phicnt_q == PW'(PHI_DIV/2));
    slot     = SW'(int'(grp_q) * SUBCYC + int'(sub_q));
    sub_last = (sub_q == 3'(SUBCYC-1));
    grp_last = (grp_q == 2'(GROUPS-1));
    rhy_grp  = i_RHYTHM_EN & (grp_q == 2'(RHY_GRP));
    mnc      = MNC8[sub_q];
    hh_next  = mnc & ~(rhy_grp & (sub_q < 3'd2));
  end

  always_comb begin
    phicnt_d = phicnt_q;
    sub_d    = sub_q;
    grp_d    = grp_q;
    frame_d  = frame_q;
    hit_d    = hit_q;
    hh_d     = hh_q;
    dly_d    = dly_q;
    if (realign) begin
      phicnt_d = '0;
      sub_d    = '0;
      grp_d    = '0;
    end else if (en) begin
      phicnt_d = (phicnt_q == PW'(PHI_DIV-1)) ? '0 : phicnt_q + PW'(1);
    end
    // ncen already excludes a realigning enable, so the two never collide
    if (ncen) begin
      hit_d    = (slot == i_CMP_SLOT);
      hh_d     = hh_next;
      dly_d[0] = slot;
      for (int unsigned i = 1; i < DLY; i++) dly_d[i] = dly_q[i-1];
      if (sub_last) begin
        sub_d = '0;
        if (grp_last) begin
          grp_d   = '0;
          frame_d = frame_q + FCW'(1);
        end else begin
          grp_d = grp_q + 2'd1;
        end
      end else begin
        sub_d = sub_q + 3'd1;
      end
    end
  end

  always_ff @(posedge i_EMUCLK or negedge i_IC_n) begin
    if (!i_IC_n) begin
      phicnt_q <= '0;
      sub_q    <= '0;
      grp_q    <= '0;
      frame_q  <= '0;
      hit_q    <= 1'b0;
      hh_q     <= 1'b0;
      for (int unsigned i = 0; i < DLY; i++) dly_q[i] <= '0;
    end else begin
      phicnt_q <= phicnt_d;
      sub_q    <= sub_d;
      grp_q    <= grp_d;
      frame_q  <= frame_d;
      hit_q    <= hit_d;
      hh_q     <= hh_d;
      dly_q    <= dly_d;
    end
  end

  // Enables are forced inactive while reset is held, even though phicnt==0.
  assign o_phi1_PCEN_n  = ~(pcen & i_IC_n);
  assign o_phi1_NCEN_n  = ~(ncen & i_IC_n);
  assign o_DAC_EN       = (phicnt_q == PW'(PHI_DIV-1));
  assign o_SUB          = sub_q;
  assign o_GRP          = grp_q;
  assign o_SLOT         = slot;
  assign o_SLOT_ZZ      = dly_q[DLY-1];
  assign o_FRAME_START  = (slot == '0);
  assign o_FRAME_CNT    = frame_q;
  assign o_CMP_HIT      = hit_q;
  assign o_MnC_SEL      = mnc;
  assign o_INHIBIT_FDBK = ~mnc & ~(rhy_grp & NOFB8[sub_q]);
  assign o_HH_TT_SEL    = hh_q;

endmodule
